command_decoder: RTL



---
 rtl/command_decoder.sv | 82 ++++++++
 1 files changed

// File: rtl/command_decoder.sv
// command_decoder: assembles UART bytes into 1-byte short and 5-byte long host commands
module command_decoder #(
  parameter int unsigned TIMEOUT_CYCLES = 100000
) (
  input  logic        clock,
  input  logic        ext_reset_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        rx_error,
  output logic [7:0]  opcode,
  output logic [31:0] command,
  output logic        cmd_recv_rx,
  output logic        cmd_long,
  output logic        timeout_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES);
  typedef enum logic {IDLE, ARGS} state_t;
  state_t      state_q;
  logic [1:0]  idx_q;
  logic [CW-1:0] cnt_q;
  logic [7:0]  pend_op_q, opcode_q;
  logic [31:0] pend_arg_q, command_q;
  logic        recv_q, long_q, timeout_q;
  assign opcode      = opcode_q;
  assign command     = command_q;
  assign cmd_recv_rx = recv_q;
  assign cmd_long    = long_q;
  assign timeout_err = timeout_q;
  always_ff @(posedge clock or negedge ext_reset_n) begin
    if (!ext_reset_n) begin
      state_q    <= IDLE;
      idx_q      <= '0;
      cnt_q      <= '0;
      pend_op_q  <= '0;
      pend_arg_q <= '0;
      opcode_q   <= '0;
      command_q  <= '0;
      recv_q     <= 1'b0;
      long_q     <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      recv_q    <= 1'b0;
      timeout_q <= 1'b0;
      // a framing error beats a coincident byte and drops any partial command
      if (rx_error) begin
        state_q <= IDLE;
        idx_q   <= '0;
        cnt_q   <= '0;
      end else if (state_q == IDLE) begin
        if (rx_valid && !rx_data[7]) begin
          opcode_q  <= rx_data;
          command_q <= '0;
          long_q    <= 1'b0;
          recv_q    <= 1'b1;
        end else if (rx_valid) begin
          pend_op_q <= rx_data;
          idx_q     <= '0;
          cnt_q     <= '0;
          state_q   <= ARGS;
        end
      end else if (rx_valid) begin
        pend_arg_q[{idx_q, 3'b000} +: 8] <= rx_data;
        idx_q <= idx_q + 2'd1;
        cnt_q <= '0;
        if (idx_q == 2'd3) begin
          opcode_q  <= pend_op_q;
          command_q <= {rx_data, pend_arg_q[23:0]};
          long_q    <= 1'b1;
          recv_q    <= 1'b1;
          state_q   <= IDLE;
        end
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        timeout_q <= 1'b1;
        state_q   <= IDLE;
        idx_q     <= '0;
        cnt_q     <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end
endmodule
